// File: rtl/nim_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : nim_pkg
// Brief  : Shared types and defaults for the Nim move controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
package nim_pkg;

   localparam int NUM_PILES_DEF = 3;
   localparam int PILE_W_DEF    = 4;

   // Pile 0 sits in the least significant nibble: piles {3,5,7}.
   localparam logic [NUM_PILES_DEF*PILE_W_DEF-1:0] INIT_PILES_DEF = 12'h753;

   typedef logic [1:0] pile_idx_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SUB    = 3'd2,
      ST_COMMIT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage : nim_pkg
`default_nettype wire

// File: rtl/pile_subtractor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : pile_subtractor
// Brief  : Combinational a - b with borrow out; the controller's single
//          arithmetic resource, shared by all piles through a select mux.
// Rev    : 1.0
//------------------------------------------------------------------------------
module pile_subtractor #(
   parameter int PILE_W = 4
) (
   input  logic [PILE_W-1:0] i_a,
   input  logic [PILE_W-1:0] i_b,
   output logic [PILE_W-1:0] o_diff,
   output logic              o_borrow
);

   logic [PILE_W:0] w_full;

   // Extend by one bit so the MSB of the result is the borrow.
   always_comb begin
      w_full   = {1'b0, i_a} - {1'b0, i_b};
      o_diff   = w_full[PILE_W-1:0];
      o_borrow = w_full[PILE_W];
   end

endmodule : pile_subtractor
`default_nettype wire

// File: rtl/nim_move_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : nim_move_controller
// Brief  : Accepts, validates and applies one Nim move at a time, alternates
//          the player and detects end of game.
// Rev    : 1.0
//------------------------------------------------------------------------------
module nim_move_controller
   import nim_pkg::*;
#(
   parameter int                            NUM_PILES  = NUM_PILES_DEF,
   parameter int                            PILE_W     = PILE_W_DEF,
   parameter logic [NUM_PILES*PILE_W-1:0]   INIT_PILES = INIT_PILES_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          new_game,
   input  logic                          move_valid,
   input  logic [1:0]                    pile_sel,
   input  logic [PILE_W-1:0]             take_amt,
   output logic                          move_ready,
   output logic                          move_ok,
   output logic                          move_err,
   output logic                          player,
   output logic [NUM_PILES*PILE_W-1:0]   piles,
   output logic                          game_over,
   output logic                          winner
);

   state_t            r_state;
   logic [PILE_W-1:0] r_piles [NUM_PILES];
   pile_idx_t         r_sel;
   logic [PILE_W-1:0] r_amt;
   logic [PILE_W-1:0] r_diff;
   logic              r_err;
   logic              r_player;
   logic              r_game_over;
   logic              r_winner;

   logic [PILE_W-1:0] w_cur;
   logic              w_sel_ok;
   logic [PILE_W-1:0] w_diff;
   logic              w_borrow;
   logic              w_reject;
   logic              w_all_zero;

   // Select the addressed pile; out-of-range selects read as zero.
   always_comb begin
      w_cur    = '0;
      w_sel_ok = 1'b0;
      for (int i = 0; i < NUM_PILES; i++) begin
         if (r_sel == pile_idx_t'(i)) begin
            w_cur    = r_piles[i];
            w_sel_ok = 1'b1;
         end
      end
   end

   pile_subtractor #(
      .PILE_W (PILE_W)
   ) u_sub (
      .i_a      (w_cur),
      .i_b      (r_amt),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   // A borrow in CHECK means take_amt exceeds the pile count.
   always_comb begin
      w_reject = !w_sel_ok || (r_amt == '0) || w_borrow;
   end

   // End-of-game test on the pile values as they will be after the commit.
   always_comb begin
      w_all_zero = 1'b1;
      for (int i = 0; i < NUM_PILES; i++) begin
         if (((r_sel == pile_idx_t'(i)) ? r_diff : r_piles[i]) != '0) begin
            w_all_zero = 1'b0;
         end
      end
   end

   // Move sequencer and pile/player state.
   always_ff @(posedge clk) begin
      if (reset || new_game) begin
         r_state     <= ST_IDLE;
         r_sel       <= '0;
         r_amt       <= '0;
         r_diff      <= '0;
         r_err       <= 1'b0;
         r_player    <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
         for (int i = 0; i < NUM_PILES; i++) begin
            r_piles[i] <= INIT_PILES[i*PILE_W +: PILE_W];
         end
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (move_valid) begin
                  r_sel   <= pile_sel;
                  r_amt   <= take_amt;
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_reject) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_SUB;
               end
            end
            ST_SUB: begin
               assert (!w_borrow);
               r_diff  <= w_diff;
               r_state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               for (int i = 0; i < NUM_PILES; i++) begin
                  if (r_sel == pile_idx_t'(i)) begin
                     r_piles[i] <= r_diff;
                  end
               end
               if (w_all_zero) begin
                  r_winner    <= r_player;
                  r_game_over <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_player <= ~r_player;
                  r_state  <= ST_IDLE;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Flatten pile registers onto the output bus, pile 0 in the LSBs.
   generate
      for (genvar g = 0; g < NUM_PILES; g++) begin : g_pack
         assign piles[g*PILE_W +: PILE_W] = r_piles[g];
      end
   endgenerate

   // A restart landing in COMMIT aborts the move, so suppress its pulse.
   always_comb begin
      move_ready = (r_state == ST_IDLE);
      move_ok    = (r_state == ST_COMMIT) && !reset && !new_game;
      move_err   = r_err;
      player     = r_player;
      game_over  = r_game_over;
      winner     = r_winner;
   end

endmodule : nim_move_controller
`default_nettype wire

// File: tb/tb_nim_move_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_nim_move_controller
// Brief  : Directed, table-driven self-checking bench for nim_move_controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_nim_move_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        new_game;
   logic        move_valid;
   logic [1:0]  pile_sel;
   logic [3:0]  take_amt;
   logic        move_ready;
   logic        move_ok;
   logic        move_err;
   logic        player;
   logic [11:0] piles;
   logic        game_over;
   logic        winner;

   int n_checks = 0;
   int n_fail   = 0;

   nim_move_controller dut (
      .clk        (clk),
      .reset      (reset),
      .new_game   (new_game),
      .move_valid (move_valid),
      .pile_sel   (pile_sel),
      .take_amt   (take_amt),
      .move_ready (move_ready),
      .move_ok    (move_ok),
      .move_err   (move_err),
      .player     (player),
      .piles      (piles),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   // Watchdog: the bench is fixed-length, so this only fires on a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // One full request/response; inputs applied just after a clock edge.
   task automatic do_move(input logic [1:0] sel, input logic [3:0] amt, input bit exp_ok);
      pile_sel   = sel;
      take_amt   = amt;
      move_valid = 1'b1;
      check("ready_before_accept", move_ready, 1);
      tick();                              // accept edge
      move_valid = 1'b0;
      check("ready_in_check", move_ready, 0);
      check("err_in_check", move_err, 0);
      tick();
      if (!exp_ok) begin
         check("err_pulse", move_err, 1);
         check("ready_after_err", move_ready, 1);
         tick();
         check("err_one_cycle", move_err, 0);
      end else begin
         check("no_err_in_sub", move_err, 0);
         check("no_ok_in_sub", move_ok, 0);
         tick();
         check("ok_pulse", move_ok, 1);
         tick();
         check("ok_one_cycle", move_ok, 0);
      end
   endtask

   typedef struct {
      bit          rst;
      logic [1:0]  sel;
      logic [3:0]  amt;
      bit          ok;
      logic [11:0] exp_piles;
      bit          exp_player;
      bit          exp_go;
      bit          exp_win;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int accepts;
      int oks;

      // {reset first, pile, take, legal, piles after, player, game_over, winner}
      tbl[0] = '{1'b1, 2'd2, 4'd4, 1'b1, 12'h353, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 2'd0, 4'd5, 1'b0, 12'h753, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 2'd1, 4'd0, 1'b0, 12'h753, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 2'd3, 4'd1, 1'b0, 12'h753, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 2'd2, 4'd8, 1'b0, 12'h753, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 2'd0, 4'd3, 1'b1, 12'h750, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 2'd1, 4'd5, 1'b1, 12'h700, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 2'd2, 4'd7, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0};

      reset      = 1'b0;
      new_game   = 1'b0;
      move_valid = 1'b0;
      pile_sel   = 2'd0;
      take_amt   = 4'd0;

      // Reset state
      do_reset();
      check("rst_piles", piles, 12'h753);
      check("rst_player", player, 0);
      check("rst_ready", move_ready, 1);
      check("rst_ok", move_ok, 0);
      check("rst_err", move_err, 0);
      check("rst_game_over", game_over, 0);
      check("rst_winner", winner, 0);

      // Table: single moves and a full game ending with player 0 winning
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].rst) do_reset();
         do_move(tbl[i].sel, tbl[i].amt, tbl[i].ok);
         check($sformatf("v%0d_piles", i), piles, tbl[i].exp_piles);
         check($sformatf("v%0d_player", i), player, tbl[i].exp_player);
         check($sformatf("v%0d_game_over", i), game_over, tbl[i].exp_go);
         check($sformatf("v%0d_winner", i), winner, tbl[i].exp_win);
         check($sformatf("v%0d_ready", i), move_ready, !tbl[i].exp_go);
      end

      // Game over: requests ignored, nothing pulses, piles stay zero
      pile_sel   = 2'd0;
      take_amt   = 4'd1;
      move_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("done_ready", move_ready, 0);
         check("done_ok", move_ok, 0);
         check("done_err", move_err, 0);
      end
      move_valid = 1'b0;
      check("done_piles", piles, 12'h000);
      check("done_game_over", game_over, 1);

      // new_game leaves DONE
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check("ng_piles", piles, 12'h753);
      check("ng_game_over", game_over, 0);
      check("ng_ready", move_ready, 1);

      // new_game during SUB aborts the move
      pile_sel   = 2'd1;
      take_amt   = 4'd2;
      move_valid = 1'b1;
      tick();                              // accept
      move_valid = 1'b0;
      tick();                              // now in SUB
      check("abort_sub_no_ok", move_ok, 0);
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check("abort_sub_ok", move_ok, 0);
      check("abort_sub_piles", piles, 12'h753);
      check("abort_sub_player", player, 0);
      check("abort_sub_ready", move_ready, 1);
      tick();
      check("abort_sub_ok_later", move_ok, 0);

      // new_game during COMMIT: no pulse and no write
      move_valid = 1'b1;
      tick();
      move_valid = 1'b0;
      tick();
      tick();                              // now in COMMIT
      new_game = 1'b1;
      #1;
      check("abort_commit_ok", move_ok, 0);
      tick();
      new_game = 1'b0;
      check("abort_commit_piles", piles, 12'h753);
      check("abort_commit_player", player, 0);

      // move_valid held across two full moves: one accept per IDLE visit
      do_reset();
      pile_sel   = 2'd1;
      take_amt   = 4'd1;
      move_valid = 1'b1;
      accepts    = 0;
      oks        = 0;
      for (int c = 0; c < 8; c++) begin
         if (move_ready) accepts++;
         tick();
         if (move_ok) oks++;
      end
      move_valid = 1'b0;
      tick();
      check("hold_accepts", accepts, 2);
      check("hold_oks", oks, 2);
      check("hold_piles", piles, 12'h733);
      check("hold_player", player, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_nim_move_controller
`default_nettype wire
